// File: rtl/uart_frame_pkg.sv
// Shared constants and the frame-field index type for the result-frame receiver.
package uart_frame_pkg;

  localparam logic [7:0] FRAME_HDR  = 8'h22;
  localparam logic [7:0] FRAME_MARK = 8'hFF;
  localparam logic [7:0] FRAME_TRL  = 8'h55;
  localparam int         FRAME_LEN  = 11;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_STOP = 3'd1;
  localparam logic [2:0] ERR_FMT  = 3'd2;
  localparam logic [2:0] ERR_MARK = 3'd3;
  localparam logic [2:0] ERR_TRL  = 3'd4;
  localparam logic [2:0] ERR_TMO  = 3'd5;

  typedef enum logic [3:0] {
    IDX_HUNT, IDX_1, IDX_2, IDX_3, IDX_4, IDX_5,
    IDX_6, IDX_7, IDX_8, IDX_9, IDX_10
  } idx_t;

  // Header is not counted as a field, so the trailer sits at FRAME_LEN-1.
  function automatic logic last_field(idx_t i);
    return i == idx_t'(FRAME_LEN - 1);
  endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Decoded-frame result bus: the receiver drives it (master), a consumer reads it (slave).
interface uart_frame_rx_if;
  logic [15:0] frame_str;
  logic [3:0]  frame_digit;
  logic        frame_valid;
  logic        frame_err;
  logic [2:0]  err_code;
  logic [15:0] frame_cnt;

  modport master (output frame_str, frame_digit, frame_valid, frame_err, err_code, frame_cnt);
  modport slave  (input  frame_str, frame_digit, frame_valid, frame_err, err_code, frame_cnt);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling, byte strobe or stop-bit error
// in the stop-bit sample cycle.
module uart_rx_byte #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_ferr
);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;

  localparam int            CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LIM = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LIM = CW'(BAUD_DIV - 1);

  bstate_t       state, state_nxt;
  logic          rx_m, rx_s, rx_q;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  // Start bit is checked at its centre; every later sample is one full bit after that.
  assign tick = (state == B_START) ? (cnt == HALF_LIM) : (cnt == FULL_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= B_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_strobe = 1'b0;
    rx_ferr   = 1'b0;
    case (state)
      B_IDLE:  if (rx_q && !rx_s) state_nxt = B_START;
      B_START: if (tick) state_nxt = rx_s ? B_IDLE : B_DATA;
      B_DATA:  if (tick && bit_idx == 3'd7) state_nxt = B_STOP;
      B_STOP: begin
        if (tick) begin
          state_nxt = B_IDLE;
          rx_strobe = rx_s;
          rx_ferr   = !rx_s;
        end
      end
      default: state_nxt = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      rx_byte <= 8'd0;
    end else begin
      cnt <= (state == B_IDLE || tick) ? '0 : cnt + 1'b1;
      if (state == B_START) bit_idx <= 3'd0;
      if (state == B_DATA && tick) begin
        bit_idx <= bit_idx + 3'd1;
        rx_byte <= {rx_s, rx_byte[7:1]};
      end
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Result-frame decoder: validates the 11-byte frame and republishes it one clock after
// the trailer's stop-bit sample; rejected frames pulse frame_err and leave results untouched.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx,
  uart_frame_rx_if.master result
);

  localparam int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int TMO_LIM  = TIMEOUT_BITS * BAUD_DIV;
  localparam int TW       = $clog2(TMO_LIM);

  logic [7:0]  rx_byte;
  logic        rx_strobe, rx_ferr;
  idx_t        idx, idx_nxt;
  logic [TW-1:0] tmo_cnt;
  logic        tmo_hit;
  logic        field_ok, commit, err;
  logic [2:0]  fail_code, cause;
  logic [15:0] sh_str;
  logic [3:0]  sh_digit;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .rx_ferr   (rx_ferr)
  );

  assign tmo_hit = (idx != IDX_HUNT) && (tmo_cnt == TW'(TMO_LIM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= IDX_HUNT;
      tmo_cnt <= '0;
    end else begin
      idx     <= idx_nxt;
      tmo_cnt <= (idx == IDX_HUNT || rx_strobe || rx_ferr || tmo_hit) ? '0 : tmo_cnt + 1'b1;
    end
  end

  always_comb begin
    idx_nxt   = idx;
    commit    = 1'b0;
    err       = 1'b0;
    cause     = ERR_NONE;
    field_ok  = 1'b1;
    fail_code = ERR_FMT;
    case (idx)
      IDX_1, IDX_2, IDX_3, IDX_4: field_ok = (rx_byte[7:1] == 7'd0);
      IDX_5, IDX_6, IDX_7, IDX_9: field_ok = (rx_byte[7:4] == 4'd0);
      IDX_8: begin
        field_ok  = (rx_byte == FRAME_MARK);
        fail_code = ERR_MARK;
      end
      IDX_10: begin
        field_ok  = (rx_byte == FRAME_TRL);
        fail_code = ERR_TRL;
      end
      default: field_ok = 1'b1;
    endcase

    // A byte event in the same cycle as the timeout wins.
    if (rx_ferr) begin
      err     = 1'b1;
      cause   = ERR_STOP;
      idx_nxt = IDX_HUNT;
    end else if (rx_strobe) begin
      if (idx == IDX_HUNT) begin
        if (rx_byte == FRAME_HDR) idx_nxt = IDX_1;
      end else if (!field_ok) begin
        err     = 1'b1;
        cause   = fail_code;
        idx_nxt = (rx_byte == FRAME_HDR) ? IDX_1 : IDX_HUNT;
      end else if (last_field(idx)) begin
        commit  = 1'b1;
        idx_nxt = IDX_HUNT;
      end else begin
        idx_nxt = idx_t'(idx + 4'd1);
      end
    end else if (tmo_hit) begin
      err     = 1'b1;
      cause   = ERR_TMO;
      idx_nxt = IDX_HUNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_str   <= 16'd0;
      sh_digit <= 4'd0;
    end else if (rx_strobe && field_ok) begin
      case (idx)
        IDX_1:   sh_str[15]   <= rx_byte[0];
        IDX_2:   sh_str[14]   <= rx_byte[0];
        IDX_3:   sh_str[13]   <= rx_byte[0];
        IDX_4:   sh_str[12]   <= rx_byte[0];
        IDX_5:   sh_str[11:8] <= rx_byte[3:0];
        IDX_6:   sh_str[7:4]  <= rx_byte[3:0];
        IDX_7:   sh_str[3:0]  <= rx_byte[3:0];
        IDX_9:   sh_digit     <= rx_byte[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result.frame_str   <= 16'd0;
      result.frame_digit <= 4'd0;
      result.frame_valid <= 1'b0;
      result.frame_err   <= 1'b0;
      result.err_code    <= 3'd0;
      result.frame_cnt   <= 16'd0;
    end else begin
      result.frame_valid <= commit;
      result.frame_err   <= err;
      if (err) result.err_code <= cause;
      if (commit) begin
        result.frame_str   <= sh_str;
        result.frame_digit <= sh_digit;
        result.frame_cnt   <= result.frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx at a fast baud (32 clocks per bit) so all frames fit a short run.
module tb_uart_frame_rx;

  localparam int DIV = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;

  int checks = 0;
  int errors = 0;

  int valid_pulses = 0;
  int err_pulses = 0;
  int strobes = 0;
  int both_hi = 0;

  int v0, e0, s0;

  localparam logic [87:0] F1  = 88'h22_01_00_01_00_07_03_0A_FF_05_55;
  localparam logic [87:0] F2  = 88'h22_00_01_00_01_09_02_0B_FF_07_55;
  localparam logic [87:0] F1B = 88'h22_01_00_01_00_07_03_0A_FE_05_55;

  uart_frame_rx_if res ();

  uart_frame_rx #(
    .CLK_FREQ     (50_000_000),
    .BAUD         (1_562_500),
    .TIMEOUT_BITS (40)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (rx),
    .result (res)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (res.frame_valid) valid_pulses++;
      if (res.frame_err) err_pulses++;
      if (res.frame_valid && res.frame_err) both_hi++;
      if (dut.u_byte.rx_strobe) strobes++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
  endtask

  // Sends bytes first..last (0 = header) of an 11-byte frame image.
  task automatic send_range(input logic [87:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(f[87 - 8*i -: 8], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * DIV) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    v0 = valid_pulses;
    e0 = err_pulses;
    s0 = strobes;
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] str, input logic [3:0] dig,
                               input logic [2:0] code, input logic [15:0] cnt);
    @(negedge clk);
    check({tag, "_str"}, 32'(res.frame_str), 32'(str));
    check({tag, "_digit"}, 32'(res.frame_digit), 32'(dig));
    check({tag, "_code"}, 32'(res.err_code), 32'(code));
    check({tag, "_cnt"}, 32'(res.frame_cnt), 32'(cnt));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", 16'h0000, 4'd0, 3'd0, 16'd0);
    check("reset_valid", 32'(res.frame_valid), 32'd0);
    check("reset_err", 32'(res.frame_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_bits(2);

    // Test 1: clean frame
    mark();
    send_range(F1, 0, 10);
    idle_bits(2);
    check_outputs("t1", 16'hA73A, 4'd5, 3'd0, 16'd1);
    check("t1_valid", 32'(valid_pulses - v0), 32'd1);
    check("t1_err", 32'(err_pulses - e0), 32'd0);
    check("t1_strobes", 32'(strobes - s0), 32'd11);

    // Test 2: leading noise bytes in HUNT
    mark();
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h33, 1'b1);
    send_range(F1, 0, 10);
    idle_bits(2);
    check_outputs("t2", 16'hA73A, 4'd5, 3'd0, 16'd2);
    check("t2_valid", 32'(valid_pulses - v0), 32'd1);
    check("t2_err", 32'(err_pulses - e0), 32'd0);

    // Test 3: bad marker then a good frame
    mark();
    send_range(F1B, 0, 10);
    idle_bits(2);
    check_outputs("t3_bad", 16'hA73A, 4'd5, 3'd3, 16'd2);
    check("t3_bad_err", 32'(err_pulses - e0), 32'd1);
    check("t3_bad_valid", 32'(valid_pulses - v0), 32'd0);
    mark();
    send_range(F2, 0, 10);
    idle_bits(2);
    check_outputs("t3_good", 16'h592B, 4'd7, 3'd3, 16'd3);
    check("t3_good_valid", 32'(valid_pulses - v0), 32'd1);

    // Test 4: stop-bit error on byte 6, then an idle glitch
    mark();
    send_range(F1, 0, 5);
    send_byte(8'h03, 1'b0);
    idle_bits(2);
    send_range(F1, 7, 10);
    idle_bits(2);
    check_outputs("t4", 16'h592B, 4'd7, 3'd1, 16'd3);
    check("t4_err", 32'(err_pulses - e0), 32'd1);
    check("t4_valid", 32'(valid_pulses - v0), 32'd0);
    mark();
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    idle_bits(3);
    check("t4_glitch_strobes", 32'(strobes - s0), 32'd0);
    check("t4_glitch_err", 32'(err_pulses - e0), 32'd0);

    // Test 5a: 41-bit gap inside a frame
    mark();
    send_range(F1, 0, 4);
    idle_bits(41);
    @(negedge clk);
    check("t5_tmo_code", 32'(res.err_code), 32'd5);
    check("t5_tmo_err", 32'(err_pulses - e0), 32'd1);
    check("t5_tmo_valid", 32'(valid_pulses - v0), 32'd0);

    // Test 5b: header arriving at index 3 resyncs
    mark();
    send_range(F1, 0, 2);
    send_range(F1, 0, 10);
    idle_bits(2);
    check_outputs("t5_resync", 16'hA73A, 4'd5, 3'd2, 16'd4);
    check("t5_resync_err", 32'(err_pulses - e0), 32'd1);
    check("t5_resync_valid", 32'(valid_pulses - v0), 32'd1);

    // Test 6: reset in the middle of byte 7
    send_range(F2, 0, 6);
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(F2[87 - 56 - 8 + 1 + i]);
    rst_n = 1'b0;
    #1;
    check_outputs("t6_rst", 16'h0000, 4'd0, 3'd0, 16'd0);
    check("t6_rst_valid", 32'(res.frame_valid), 32'd0);
    check("t6_rst_err", 32'(res.frame_err), 32'd0);
    for (int i = 4; i < 8; i++) bit_out(F2[87 - 56 - 8 + 1 + i]);
    bit_out(1'b1);
    rst_n = 1'b1;
    mark();
    send_range(F2, 8, 10);
    idle_bits(2);
    check("t6_tail_valid", 32'(valid_pulses - v0), 32'd0);
    mark();
    send_range(F2, 0, 10);
    idle_bits(2);
    check_outputs("t6_after", 16'h592B, 4'd7, 3'd0, 16'd1);
    check("t6_after_valid", 32'(valid_pulses - v0), 32'd1);

    check("never_both", 32'(both_hi), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
